// File: rtl/wb_led_pwm_if.sv
// wb_led_pwm_if: pipelined Wishbone bus bundle between a master and the LED PWM slave
interface wb_led_pwm_if;
    logic [31:0] data_m;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] data_s;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output data_m, addr, sel, cyc, stb, we,
        input  data_s, ack, stall, err
    );

    modport slave (
        input  data_m, addr, sel, cyc, stb, we,
        output data_s, ack, stall, err
    );
endinterface

// File: rtl/wb_led_pwm.sv
// wb_led_pwm: Wishbone pipelined slave generating glitch-free 8-bit PWM per LED
module wb_led_pwm #(
    parameter int LedCount      = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    wb_led_pwm_if.slave         bus,
    output logic [LedCount-1:0] leds
);
    localparam int DataWidth = 32;
    localparam int AddrWidth = 32;
    localparam int SelWidth  = 4;

    logic                         ctrl_en;
    logic                         ctrl_inv;
    logic [PrescaleWidth-1:0]     prescale;
    logic [PrescaleWidth-1:0]     pre_cnt;
    logic [LedCount-1:0][7:0]     duty;
    logic [LedCount-1:0][7:0]     shadow;
    logic [7:0]                   pwm_cnt;
    logic [2:0]                   idx;
    logic                         accept;
    logic                         mapped;
    logic                         wr;
    logic                         tick;
    logic                         wrap;
    logic [DataWidth-1:0]         rd_val;
    logic [DataWidth-1:0]         wmask;
    logic [DataWidth-1:0]         merged;
    logic [LedCount-1:0]          cmp;
    logic                         unused_addr;

    assign unused_addr = ^{bus.addr[AddrWidth-1:5], bus.addr[1:0]};
    assign bus.stall   = 1'b0;
    assign idx         = bus.addr[4:2];
    assign accept      = bus.cyc && bus.stb;
    assign mapped      = !idx[2];
    assign wr          = accept && mapped && bus.we;
    assign tick        = ctrl_en && (pre_cnt == prescale);
    assign wrap        = tick && (pwm_cnt == 8'hFF);

    // Read mux, byte-lane write merge and per-LED duty compare
    always_comb begin
        rd_val = idx == 3'd0 ? DataWidth'({ctrl_inv, ctrl_en})
               : idx == 3'd1 ? DataWidth'(prescale)
               : idx == 3'd2 ? DataWidth'(duty)
               : idx == 3'd3 ? DataWidth'(pwm_cnt) : '0;
        for (int i = 0; i < SelWidth; i++) wmask[8*i +: 8] = {8{bus.sel[i]}};
        merged = (rd_val & ~wmask) | (bus.data_m & wmask);
        for (int i = 0; i < LedCount; i++) cmp[i] = pwm_cnt < shadow[i];
    end

    // Bus response: one registered ack or err pulse per accepted strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.ack    <= 1'b0;
            bus.err    <= 1'b0;
            bus.data_s <= '0;
        end else begin
            bus.ack    <= accept && mapped;
            bus.err    <= accept && !mapped;
            bus.data_s <= (accept && mapped && !bus.we) ? rd_val : '0;
        end
    end

    // Programmable registers; COUNT and unmapped writes have no side effect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en  <= 1'b0;
            ctrl_inv <= 1'b0;
            prescale <= '0;
            duty     <= '0;
        end else if (wr) begin
            if (idx == 3'd0) {ctrl_inv, ctrl_en} <= merged[1:0];
            if (idx == 3'd1) prescale <= merged[PrescaleWidth-1:0];
            if (idx == 3'd2) duty <= merged[8*LedCount-1:0];
        end
    end

    // Prescaler, PWM counter, shadow reload at period wrap and registered LED drive
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            shadow  <= '0;
            leds    <= '0;
        end else begin
            if (wr && idx == 3'd1) pre_cnt <= '0;
            else if (ctrl_en) pre_cnt <= tick ? '0 : pre_cnt + PrescaleWidth'(1);
            pwm_cnt <= !ctrl_en ? 8'd0 : tick ? pwm_cnt + 8'd1 : pwm_cnt;
            if (!ctrl_en || wrap) shadow <= duty;
            leds <= {LedCount{ctrl_inv}} ^ (ctrl_en ? cmp : '0);
        end
    end
endmodule

// File: tb/tb_wb_led_pwm.sv
// tb_wb_led_pwm: randomized self-checking bench for the Wishbone LED PWM slave
module tb_wb_led_pwm;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  leds;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_ctrl = '0;
    logic [15:0] m_pre = '0;
    logic [31:0] m_duty = '0;

    wb_led_pwm_if bus();

    wb_led_pwm #(.LedCount(4), .PrescaleWidth(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .leds(leds)
    );

    always #5 clk = ~clk;

    // Stall must never assert once out of reset
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL stall got=%b want=0", bus.stall);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    return {30'b0, m_ctrl};
            3'd1:    return {16'b0, m_pre};
            3'd2:    return m_duty;
            default: return 32'b0;
        endcase
    endfunction

    task automatic idle();
        bus.cyc = 0; bus.stb = 0; bus.we = 0;
        bus.addr = '0; bus.data_m = '0; bus.sel = '0;
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, output logic [31:0] rd, output logic a,
                        output logic e);
        @(posedge clk); #1;
        bus.cyc = 1; bus.stb = 1; bus.we = we;
        bus.addr = addr; bus.data_m = data; bus.sel = sel;
        @(posedge clk); #1;
        idle();
        rd = bus.data_s; a = bus.ack; e = bus.err;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] rd, m;
        logic a, e;
        xfer(1'b1, addr, data, sel, rd, a, e);
        m = lane_merge(model_reg(addr[4:2]), data, sel);
        case (addr[4:2])
            3'd0:    m_ctrl = m[1:0];
            3'd1:    m_pre = m[15:0];
            3'd2:    m_duty = m;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic a, e;
        reset_n = 0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ack, bus.err, bus.data_s, leds} !== 38'b0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b err=%b data=%h leds=%b want all 0",
                     bus.ack, bus.err, bus.data_s, leds);
        end
        reset_n = 1;
        m_ctrl = 0; m_pre = 0; m_duty = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'(4 * i), 32'h0, 4'hF, rd, a, e);
            checks++;
            if (a !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read%0d ack=%b err=%b data=%h want ack=1 err=0 data=0",
                         i, a, e, rd);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.ack !== 1'b0 || bus.data_s !== 32'h0) begin
                errors++;
                $display("FAIL ack_pulse%0d ack=%b data=%h want 0", i, bus.ack, bus.data_s);
            end
        end
        checks++;
        if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL reset_leds got=%b want=0000", leds);
        end
    endtask

    task automatic test_pwm();
        logic [7:0] d[4];
        int cnt[4];
        int expv;
        logic inv;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                d = '{8'h40, 8'h80, 8'hFF, 8'h00};
                inv = 0;
            end else begin
                for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
                inv = 1'($urandom_range(1));
            end
            reg_write(32'h0, {30'b0, inv, 1'b0}, 4'hF);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (leds !== {4{inv}}) begin
                errors++;
                $display("FAIL disabled_leds it=%0d got=%b want=%b", it, leds, {4{inv}});
            end
            reg_write(32'h8, {d[3], d[2], d[1], d[0]}, 4'hF);
            reg_write(32'h4, 32'h0, 4'hF);
            reg_write(32'h0, {30'b0, inv, 1'b1}, 4'hF);
            repeat (4) @(posedge clk);
            cnt = '{0, 0, 0, 0};
            repeat (512) begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) cnt[i] += int'(leds[i]);
            end
            for (int i = 0; i < 4; i++) begin
                expv = inv ? 512 - 2 * int'(d[i]) : 2 * int'(d[i]);
                checks++;
                if (cnt[i] != expv) begin
                    errors++;
                    $display("FAIL pwm_high it=%0d led%0d duty=%h inv=%b got=%0d want=%0d",
                             it, i, d[i], inv, cnt[i], expv);
                end
            end
        end
    endtask

    task automatic test_sel();
        logic [31:0] rd, data, expv;
        logic [3:0] sel;
        logic [2:0] idx;
        logic a, e;
        reg_write(32'h8, 32'h0, 4'hF);
        reg_write(32'h8, 32'h11223344, 4'b0100);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e);
        checks++;
        if (a !== 1'b1 || rd !== 32'h00220000) begin
            errors++;
            $display("FAIL sel_duty ack=%b got=%h want=00220000", a, rd);
        end
        for (int it = 0; it < 10; it++) begin
            idx = 3'($urandom_range(2));
            data = $urandom;
            sel = 4'($urandom);
            reg_write({27'b0, idx, 2'b0}, data, sel);
            expv = model_reg(idx);
            xfer(1'b0, {27'b0, idx, 2'b0}, 32'h0, 4'hF, rd, a, e);
            checks++;
            if (a !== 1'b1 || rd !== expv) begin
                errors++;
                $display("FAIL sel_rand reg=%0d sel=%b ack=%b got=%h want=%h", idx, sel, a, rd, expv);
            end
        end
        reg_write(32'h0, 32'h0, 4'hF);
    endtask

    task automatic test_err();
        logic [31:0] rd, r, addr, expv;
        logic a, e;
        xfer(1'b0, 32'h14, 32'h0, 4'hF, rd, a, e);
        checks++;
        if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_read err=%b ack=%b data=%h want err=1 ack=0 data=0", e, a, rd);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got=%b want=0", bus.err);
        end
        xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, rd, a, e);
        checks++;
        if (e !== 1'b1 || a !== 1'b0) begin
            errors++;
            $display("FAIL err_write err=%b ack=%b want err=1 ack=0", e, a);
        end
        for (int j = 0; j < 4; j++) begin
            r = $urandom;
            addr = (r & ~32'h1C) | (32'(4 + j) << 2);
            xfer(1'($urandom_range(1)), addr, $urandom, 4'hF, rd, a, e);
            checks++;
            if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err_rand addr=%h err=%b ack=%b data=%h", addr, e, a, rd);
            end
        end
        for (int j = 0; j < 3; j++) begin
            r = $urandom;
            addr = (r & ~32'h1C) | (32'(j) << 2);
            expv = model_reg(3'(j));
            xfer(1'b0, addr, 32'h0, 4'hF, rd, a, e);
            checks++;
            if (a !== 1'b1 || e !== 1'b0 || rd !== expv) begin
                errors++;
                $display("FAIL err_state addr=%h ack=%b got=%h want=%h", addr, a, rd, expv);
            end
        end
    endtask

    task automatic test_glitchfree();
        logic [7:0] dold[4], dnew[4];
        logic [31:0] rd, c1;
        logic [3:0] prev;
        logic a, e, p0, found;
        int len, rise[4], hl[4];
        bit rose[4], fell[4];
        reg_write(32'h0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) dold[i] = 8'($urandom_range(96, 16));
        reg_write(32'h8, {dold[3], dold[2], dold[1], dold[0]}, 4'hF);
        reg_write(32'h4, 32'h3, 4'hF);
        reg_write(32'h0, 32'h1, 4'hF);
        xfer(1'b0, 32'hC, 32'h0, 4'hF, c1, a, e);
        repeat (38) @(posedge clk);
        xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, a, e);
        checks++;
        if (8'(rd[7:0] - c1[7:0]) !== 8'd10) begin
            errors++;
            $display("FAIL tick_rate count %0d -> %0d over 40 clocks, want +10", c1[7:0], rd[7:0]);
        end
        found = 0;
        p0 = leds[0];
        for (int k = 0; k < 2500 && !found; k++) begin
            @(posedge clk); #1;
            if (leds[0] && !p0) found = 1;
            p0 = leds[0];
        end
        len = 0;
        while (found && leds[0] && len < 2000) begin
            len++;
            @(posedge clk); #1;
        end
        checks++;
        if (!found || len != 4 * int'(dold[0])) begin
            errors++;
            $display("FAIL old_run found=%b got=%0d want=%0d", found, len, 4 * int'(dold[0]));
        end
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, a, e);
            if (rd[7:0] >= 8'h80 && rd[7:0] <= 8'hC0) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midperiod_wait count never reached 80..C0, last=%h", rd[7:0]);
        end
        for (int i = 0; i < 4; i++) dnew[i] = 8'($urandom_range(254, 224));
        reg_write(32'h8, {dnew[3], dnew[2], dnew[1], dnew[0]}, 4'hF);
        rose = '{0, 0, 0, 0};
        fell = '{0, 0, 0, 0};
        hl = '{0, 0, 0, 0};
        rise = '{-1, -1, -1, -1};
        prev = leds;
        checks++;
        if (prev !== 4'b0000) begin
            errors++;
            $display("FAIL midperiod_leds got=%b want=0000", prev);
        end
        for (int k = 0; k < 2500; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (!rose[i] && leds[i] && !prev[i]) begin
                    rose[i] = 1;
                    rise[i] = k;
                end
                if (rose[i] && !fell[i]) begin
                    if (leds[i]) hl[i]++;
                    else fell[i] = 1;
                end
            end
            prev = leds;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!fell[i] || hl[i] != 4 * int'(dnew[i]) || rise[i] != rise[0]) begin
                errors++;
                $display("FAIL new_run led%0d run=%0d want=%0d rise=%0d led0_rise=%0d",
                         i, hl[i], 4 * int'(dnew[i]), rise[i], rise[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expv[4];
        logic [31:0] rd;
        logic a, e;
        reg_write(32'h0, 32'h2, 4'hF);
        reg_write(32'h4, 32'h5, 4'hF);
        reg_write(32'h8, $urandom | 32'h1, 4'hF);
        for (int b = 0; b < 4; b++) expv[b] = model_reg(3'(b));
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) begin
            bus.cyc = 1; bus.stb = 1; bus.we = 0;
            bus.addr = 32'(4 * b); bus.sel = 4'hF; bus.data_m = '0;
            @(posedge clk); #1;
            checks++;
            if (bus.ack !== 1'b1 || bus.data_s !== expv[b]) begin
                errors++;
                $display("FAIL burst_beat%0d ack=%b got=%h want=%h", b, bus.ack, bus.data_s, expv[b]);
            end
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if (bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL burst_end ack=%b want=0", bus.ack);
        end
        for (int b = 0; b < 4; b++) begin
            bus.cyc = 1; bus.stb = 1; bus.we = 1;
            bus.addr = 32'h8; bus.sel = 4'hF; bus.data_m = $urandom;
            if (b == 2) reset_n = 0;
            @(posedge clk); #1;
            checks++;
            if (bus.ack !== 1'(b < 2) || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL reset_burst beat%0d ack=%b err=%b want ack=%b", b, bus.ack, bus.err, b < 2);
            end
        end
        idle();
        reset_n = 1;
        m_ctrl = 0; m_pre = 0; m_duty = 0;
        for (int b = 0; b < 4; b++) begin
            xfer(1'b0, 32'(4 * b), 32'h0, 4'hF, rd, a, e);
            checks++;
            if (a !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL post_reset reg%0d ack=%b got=%h want=0", b, a, rd);
            end
        end
        checks++;
        if (leds !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_leds got=%b want=0000", leds);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_pwm();
        test_sel();
        test_err();
        test_glitchfree();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
